// File: rtl/direction_input_controller_if.sv
// Bus between the button/board side and the direction controller:
// raw button levels, the per-cell legal-move mask, the move strobe,
// and the registered direction and queued-turn outputs.
interface direction_input_controller_if;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic [3:0] valid_moves;
    logic       move_tick;
    logic [3:0] move_direction;
    logic [3:0] pending_dir;

    // Board/stimulus side: drives buttons, mask and tick; observes results.
    modport master (
        output btn_right,
        output btn_up,
        output btn_down,
        output btn_left,
        output valid_moves,
        output move_tick,
        input  move_direction,
        input  pending_dir
    );

    // Controller side.
    modport slave (
        input  btn_right,
        input  btn_up,
        input  btn_down,
        input  btn_left,
        input  valid_moves,
        input  move_tick,
        output move_direction,
        output pending_dir
    );
endinterface

// File: rtl/direction_input_controller.sv
// Player direction controller: synchronizes and debounces four buttons,
// queues the latest press as a pending turn, and on each move tick picks
// the one-hot direction to present using the current cell's legal-move mask.
// Pressing a turn early makes it happen at the first cell where it is legal;
// the sprite stops at walls.
// Direction encoding: RIGHT=0001, UP=0010, DOWN=0100, LEFT=1000.
module direction_input_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PENDING_TICKS   = 4
) (
    input logic                         clk,
    input logic                         rst,
    direction_input_controller_if.slave bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AGE_W = $clog2(PENDING_TICKS + 1);

    // Counter value at which the next disagreeing sample completes the run.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Age value at which the next unconsumed tick expires the pending turn.
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(PENDING_TICKS - 1);

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_MOVING  = 1'b1
    } state_t;

    // Button levels packed in direction-code bit order.
    logic [3:0] btn_raw;
    assign btn_raw = {bus.btn_left, bus.btn_down, bus.btn_up, bus.btn_right};

    // ------------------------------------------------------------------
    // Synchronizer and debounce
    // ------------------------------------------------------------------
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [3:0]       deb_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Two-flop synchronizer per button, then the debounce state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '{default: '0};
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // Count consecutive samples that disagree with the debounced level;
    // a full run flips the level, any agreeing sample restarts the run.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Press events
    // ------------------------------------------------------------------
    logic [3:0] rise;
    logic [3:0] press_dir;

    assign rise = deb_q & ~deb_prev_q;

    // Simultaneous presses resolve RIGHT > LEFT > UP > DOWN; the rest are dropped.
    always_comb begin
        press_dir = DIR_NONE;
        if (rise[0]) begin
            press_dir = DIR_RIGHT;
        end else if (rise[3]) begin
            press_dir = DIR_LEFT;
        end else if (rise[1]) begin
            press_dir = DIR_UP;
        end else if (rise[2]) begin
            press_dir = DIR_DOWN;
        end
    end

    // ------------------------------------------------------------------
    // Movement state machine with single-entry pending turn
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cur_q;
    logic [3:0]       cur_d;
    logic [3:0]       pend_q;
    logic [3:0]       pend_d;
    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;
    logic [3:0]       move_q;
    logic [3:0]       move_d;
    logic             take;
    logic             cur_legal;

    // State register, including the registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STOPPED;
            cur_q   <= DIR_NONE;
            pend_q  <= DIR_NONE;
            age_q   <= '0;
            move_q  <= DIR_NONE;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            age_q   <= age_d;
            move_q  <= move_d;
        end
    end

    // Next state: the tick decision uses the pre-tick pending turn; a press
    // in the same cycle lands afterwards and overrides any clear or expiry.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pend_d    = pend_q;
        age_d     = age_q;
        take      = 1'b0;
        cur_legal = 1'b0;
        if (bus.move_tick) begin
            // A non-empty overlap implies a non-empty pending turn.
            take      = (pend_q & bus.valid_moves) != DIR_NONE;
            cur_legal = (state_q == ST_MOVING) && ((cur_q & bus.valid_moves) != DIR_NONE);
            if (take) begin
                state_d = ST_MOVING;
                cur_d   = pend_q;
                pend_d  = DIR_NONE;
                age_d   = '0;
            end else begin
                if (!cur_legal) begin
                    state_d = ST_STOPPED;
                end
                if (pend_q != DIR_NONE) begin
                    if (age_q == AGE_LAST) begin
                        pend_d = DIR_NONE;
                        age_d  = '0;
                    end else begin
                        age_d = age_q + 1'b1;
                    end
                end
            end
        end
        if (press_dir != DIR_NONE) begin
            pend_d = press_dir;
            age_d  = '0;
        end
    end

    // Output decode: present the current direction only while moving.
    always_comb begin
        move_d = DIR_NONE;
        if (state_d == ST_MOVING) begin
            move_d = cur_d;
        end
    end

    assign bus.move_direction = move_q;
    assign bus.pending_dir    = pend_q;

endmodule

// File: tb/tb_direction_input_controller.sv
// Bench for direction_input_controller with short debounce and pending
// lifetimes. A behavioural model tracks the expected outputs every cycle;
// directed scenarios pin the model with literal expectations, then a
// randomized phase exercises bouncing buttons, random ticks/masks and resets.
module tb_direction_input_controller;

    localparam int DEB = 4;
    localparam int PT  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic       tick;
    logic [3:0] vm;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    direction_input_controller_if bus ();

    assign bus.btn_right   = btn[0];
    assign bus.btn_up      = btn[1];
    assign bus.btn_down    = btn[2];
    assign bus.btn_left    = btn[3];
    assign bus.valid_moves = vm;
    assign bus.move_tick   = tick;

    direction_input_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .PENDING_TICKS  (PT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- behavioural model ----------------
    bit [3:0] m_r1, m_r2;       // raw samples from one and two edges ago
    bit [3:0] m_deb;            // accepted button levels
    int       m_run [4];        // consecutive edges the sample disagreed
    bit [3:0] m_ev;             // press decided last edge, lands this edge
    bit [3:0] m_dir;            // presented direction, 0 = stopped
    bit [3:0] m_pend;
    int       m_age;
    bit [3:0] m_s, m_rise;

    function automatic bit [3:0] pick(input bit [3:0] r);
        if (r[0]) return 4'b0001;
        if (r[3]) return 4'b1000;
        if (r[1]) return 4'b0010;
        if (r[2]) return 4'b0100;
        return 4'b0000;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst) begin
            m_r1 = '0; m_r2 = '0; m_deb = '0; m_ev = '0;
            m_dir = '0; m_pend = '0; m_age = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            if (tick) begin
                if ((m_pend & vm) != 0) begin
                    m_dir  = m_pend;
                    m_pend = '0;
                    m_age  = 0;
                end else begin
                    if ((m_dir & vm) == 0) m_dir = '0;
                    if (m_pend != 0) begin
                        m_age++;
                        if (m_age >= PT) begin
                            m_pend = '0;
                            m_age  = 0;
                        end
                    end
                end
            end
            if (m_ev != 0) begin
                m_pend = m_ev;
                m_age  = 0;
            end
            m_s  = m_r2;
            m_r2 = m_r1;
            m_r1 = btn;
            m_rise = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_s[i] == m_deb[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_deb[i] = ~m_deb[i];
                        m_run[i] = 0;
                        if (m_deb[i]) m_rise[i] = 1'b1;
                    end
                end
            end
            m_ev = pick(m_rise);
        end
    end

    // Compare DUT against the model on every falling edge out of reset.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            n_cmp++;
            if (bus.move_direction !== 4'(m_dir)) begin
                n_bad++;
                $display("FAIL model move_direction at %0t: got %b expected %b", $time, bus.move_direction, m_dir);
            end
            n_cmp++;
            if (bus.pending_dir !== 4'(m_pend)) begin
                n_bad++;
                $display("FAIL model pending_dir at %0t: got %b expected %b", $time, bus.pending_dir, m_pend);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [3:0] v);
        tick = 1'b1;
        vm   = v;
        wait_cyc(1);
        tick = 1'b0;
        vm   = 4'($urandom);
        @(negedge clk);
    endtask

    int hold [4];

    // ---------------- stimulus ----------------
    initial begin
        btn  = '0;
        tick = 1'b0;
        vm   = '0;
        rst  = 1'b0;
        wait_cyc(3);
        rst = 1'b1;

        // Reset pulse, then debounce latency of a steady UP press.
        wait_cyc(1);
        rst = 1'b0;
        #2;
        check("reset move", bus.move_direction, 4'b0000);
        check("reset pend", bus.pending_dir, 4'b0000);
        wait_cyc(1);
        rst    = 1'b1;
        btn[1] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t1 pend at 6", bus.pending_dir, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        check("t1 pend at 7", bus.pending_dir, 4'b0010);
        check("t1 move", bus.move_direction, 4'b0000);

        // Bounce rejection, then a legal RIGHT move.
        wait_cyc(1);
        btn[1] = 1'b0;
        wait_cyc(10);
        for (int k = 0; k < 10; k++) begin
            btn[0] = ~btn[0];
            wait_cyc(2);
        end
        @(negedge clk);
        check("t2 bounce pend", bus.pending_dir, 4'b0010);
        wait_cyc(1);
        btn[0] = 1'b1;
        wait_cyc(9);
        @(negedge clk);
        check("t2 pend", bus.pending_dir, 4'b0001);
        wait_cyc(1);
        do_tick(4'b1111);
        check("t2 move", bus.move_direction, 4'b0001);
        check("t2 pend clr", bus.pending_dir, 4'b0000);

        // Pre-turn UP while moving RIGHT.
        wait_cyc(1);
        btn[1] = 1'b1;
        wait_cyc(9);
        do_tick(4'b0001);
        check("t3 move hold", bus.move_direction, 4'b0001);
        check("t3 pend kept", bus.pending_dir, 4'b0010);
        wait_cyc(1);
        do_tick(4'b0011);
        check("t3 move turn", bus.move_direction, 4'b0010);
        check("t3 pend clr", bus.pending_dir, 4'b0000);

        // Turn LEFT, then let a DOWN request expire.
        wait_cyc(1);
        btn[3] = 1'b1;
        wait_cyc(9);
        do_tick(4'b1000);
        check("t4 move left", bus.move_direction, 4'b1000);
        wait_cyc(1);
        btn[2] = 1'b1;
        wait_cyc(9);
        do_tick(4'b1001);
        check("t4 pend age1", bus.pending_dir, 4'b0100);
        wait_cyc(1);
        do_tick(4'b1001);
        check("t4 pend expired", bus.pending_dir, 4'b0000);
        check("t4 move", bus.move_direction, 4'b1000);

        // Wall stop, then restart DOWN.
        wait_cyc(1);
        do_tick(4'b0110);
        check("t5 stop", bus.move_direction, 4'b0000);
        wait_cyc(1);
        btn[2] = 1'b0;
        wait_cyc(10);
        btn[2] = 1'b1;
        wait_cyc(9);
        do_tick(4'b1111);
        check("t5 move down", bus.move_direction, 4'b0100);

        // Simultaneous LEFT+UP, then a press landing on a consuming tick.
        wait_cyc(1);
        btn = '0;
        wait_cyc(12);
        btn[3] = 1'b1;
        btn[1] = 1'b1;
        wait_cyc(9);
        @(negedge clk);
        check("t6 priority", bus.pending_dir, 4'b1000);
        wait_cyc(1);
        btn[0] = 1'b1;
        wait_cyc(6);
        tick = 1'b1;
        vm   = 4'b1111;
        wait_cyc(1);
        tick = 1'b0;
        @(negedge clk);
        check("t6 move", bus.move_direction, 4'b1000);
        check("t6 new press kept", bus.pending_dir, 4'b0001);

        // Reset mid-pending with buttons held: progress cleared, fresh press after release.
        wait_cyc(1);
        rst = 1'b0;
        #2;
        check("t7 reset pend", bus.pending_dir, 4'b0000);
        check("t7 reset move", bus.move_direction, 4'b0000);
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(7);
        @(negedge clk);
        check("t7 held press", bus.pending_dir, 4'b0001);
        check("t7 move", bus.move_direction, 4'b0000);

        // Randomized phase.
        wait_cyc(1);
        for (int b = 0; b < 4; b++) hold[b] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    btn[b]  = 1'($urandom_range(0, 1));
                    hold[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                          : int'($urandom_range(6, 30));
                end else begin
                    hold[b]--;
                end
            end
            tick = ($urandom_range(0, 4) == 0);
            vm   = 4'($urandom);
            rst  = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            wait_cyc(1);
        end
        rst  = 1'b1;
        tick = 1'b0;
        wait_cyc(2);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/direction_input_controller.md
# direction_input_controller

Player-side producer of the one-hot `move_direction` code consumed by the sprite position updater. It synchronizes and debounces the four board push-buttons and queues the most recent press as a pending turn. On each move tick it picks the direction to present, using the `valid_moves` mask for the current pacman cell. The result is Pac-Man-style pre-turning: a turn pressed early is taken at the first cell where it is legal, and the sprite stops at walls.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive identical synchronized samples required to accept a new button level.
- `PENDING_TICKS`, 4: number of `move_tick` strobes a pending turn survives without being taken.

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `btn_right`, `btn_up`, `btn_down`, `btn_left`  in  1 each  raw asynchronous button levels, 1 = pressed.
- `valid_moves`  in  4  legal-move mask for the current cell, same encoding as `move_direction`; sampled only on `move_tick`.
- `move_tick`  in  1  one-`clk` strobe, one per position update.
- `move_direction`  out  4  registered one-hot direction, or 0 = stopped.
- `pending_dir`  out  4  registered queued turn, one-hot or 0.

Encoding: RIGHT = 4'b0001, UP = 4'b0010, DOWN = 4'b0100, LEFT = 4'b1000.

## Operation
- **Synchronizer:** two flops per button, reset to 0.
- **Debounce:** one counter per button, `$clog2(DEBOUNCE_CYCLES+1)` bits.
  - The counter clears whenever the synchronized sample equals the debounced level.
  - Otherwise it increments each cycle. When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Debounced levels reset to 0 (released).
- **Press event:** a 0→1 transition of a debounced level. If several occur in the same cycle, priority is RIGHT > LEFT > UP > DOWN; the rest are discarded.
- **Pending queue (single entry):**
  - A press event loads `pending_dir` and clears the age counter.
  - A press overwrites any existing pending entry.
- **State machine**, states STOPPED (`move_direction` = 0) and MOVING (`move_direction` = cur). Evaluated only in cycles where `move_tick` = 1, using the register values from before that cycle:
  - If `pending_dir` ≠ 0 and `pending_dir & valid_moves` ≠ 0: cur ← `pending_dir`, `pending_dir` ← 0, go to MOVING.
  - Else if in MOVING and `cur & valid_moves` ≠ 0: hold cur.
  - Else: go to STOPPED, `move_direction` ← 0. A pending entry is kept.
  - If `pending_dir` was not taken: age increments. When age reaches `PENDING_TICKS`, `pending_dir` ← 0.
  - Reversal (pending opposite to cur) follows the same rules; there is no special case.
- **Press event and `move_tick` in the same cycle:** the tick is evaluated with the old pending. The new press then lands in `pending_dir` with age 0, overriding any clear or expiry from that tick.
- **Button held through reset release:** it is debounced as a fresh press, and the event is generated.
- **Button release:** no effect on `move_direction` or `pending_dir`.

## Timing
- Reset (`rst` = 0, async): `move_direction` = 0, `pending_dir` = 0, state STOPPED, all counters and flops 0.
- Press-to-pending latency: 2 sync cycles + `DEBOUNCE_CYCLES` + 1 register cycle after the raw level stabilizes.
- `move_direction` changes only on the `clk` edge following a `move_tick` cycle. It is stable for the whole interval between ticks, so the downstream updater may sample it at any point in that interval.
- `valid_moves` must be settled in the `move_tick` cycle; it is ignored in all other cycles.
- Reset asserted mid-debounce or mid-pending: all progress is discarded immediately. No event is generated on release of `rst` unless the button is still pressed.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES` = 4, `PENDING_TICKS` = 2.

1. **Reset and debounce latency.** Pulse `rst` low, then hold `btn_up` = 1 steady → `pending_dir` = 0010 exactly 7 cycles after the raise; `move_direction` = 0 until a tick arrives.
2. **Bounce rejection and legal move.** Toggle `btn_right` every 2 cycles for 20 cycles → no press event. Then hold it high → `pending_dir` = 0001. Tick with `valid_moves` = 1111 → `move_direction` = 0001 and `pending_dir` = 0.
3. **Pre-turn.** While MOVING RIGHT, press UP. Tick with `valid_moves` = 0001 → still 0001, `pending_dir` = 0010. Next tick with `valid_moves` = 0011 → `move_direction` = 0010.
4. **Pending expiry.** Press DOWN, then give 2 ticks with `valid_moves` = 1001 → `pending_dir` = 0 after the second tick, and `move_direction` is unchanged.
5. **Wall stop.** MOVING LEFT, tick with `valid_moves` = 0110 → `move_direction` = 0. A later press of DOWN plus a tick → 0100.
6. **Simultaneous events.** `btn_left` and `btn_up` debounce in the same cycle → `pending_dir` = 1000. A press event coinciding with a tick that consumes the old pending → the new press is retained in `pending_dir`.
